// File: rtl/dac_timestamp_counter.sv
// dac_timestamp_counter
//   64-bit DAC-domain sample clock feeding util_upack2_timestamp. Advances by
//   SAMPLES_PER_CHANNEL per consumed sample strobe. The host may set the time
//   immediately, or (with DAC_TIMESTAMP_PPS_EN defined) on the next PPS rising
//   edge, and can read back the timestamp captured at the last PPS edge.
//
//   Optional feature macro: DAC_TIMESTAMP_PPS_EN (PPS sync, capture, ARMED state)
//
// Ports
//   dac_clk        in   sole clock
//   reset          in   synchronous, active-high
//   counter_en     in   1: count on sample_strobe, 0: hold
//   sample_strobe  in   one DAC sample consumed
//   load_value     in   [63:0] time to load
//   load_mode      in   0: immediate, 1: on next PPS edge
//   load_req       in   single-cycle load request
//   load_cancel    in   abort an armed PPS load
//   load_busy      out  PPS load armed
//   load_done      out  pulse in the cycle timestamp first shows the loaded value
//   pps_in         in   asynchronous PPS input
//   pps_timestamp  out  [63:0] timestamp captured at the last PPS edge
//   pps_count      out  [31:0] PPS edges seen (wrapping)
//   timestamp      out  [63:0] current time
module dac_timestamp_counter #(
  parameter int unsigned SAMPLES_PER_CHANNEL = 1,
  parameter int unsigned PPS_SYNC_STAGES     = 2
) (
  input  logic        dac_clk,
  input  logic        reset,
  input  logic        counter_en,
  input  logic        sample_strobe,
  input  logic [63:0] load_value,
  input  logic        load_mode,
  input  logic        load_req,
  input  logic        load_cancel,
  output logic        load_busy,
  output logic        load_done,
  input  logic        pps_in,
  output logic [63:0] pps_timestamp,
  output logic [31:0] pps_count,
  output logic [63:0] timestamp
);

  localparam int unsigned TS_W  = 64;
  localparam int unsigned CNT_W = 32;
  localparam logic [TS_W-1:0] STEP = TS_W'(SAMPLES_PER_CHANNEL);

  logic            w_count;
  logic [TS_W-1:0] w_ts_inc;

  assign w_count  = counter_en & sample_strobe;
  assign w_ts_inc = timestamp + STEP;

`ifdef DAC_TIMESTAMP_PPS_EN

  if (PPS_SYNC_STAGES < 2 || PPS_SYNC_STAGES > 4) begin : g_bad_stages
    $error("PPS_SYNC_STAGES must be in 2..4");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [TS_W-1:0]        r_hold;
  // Synchronizer stages plus one extra flop used as the edge-detect history.
  logic [PPS_SYNC_STAGES:0] r_pps_sync;
  logic                   w_pps_edge;

  assign w_pps_edge = r_pps_sync[PPS_SYNC_STAGES-1] & ~r_pps_sync[PPS_SYNC_STAGES];

  // Counter, PPS capture and load FSM. Later assignments to timestamp give
  // loads priority over the strobe increment.
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_pps_sync    <= '0;
      timestamp     <= '0;
      pps_timestamp <= '0;
      pps_count     <= '0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      r_pps_sync <= {r_pps_sync[PPS_SYNC_STAGES-1:0], pps_in};
      load_done  <= 1'b0;

      if (w_count) begin
        timestamp <= w_ts_inc;
      end

      // Capture uses the pre-load value of timestamp.
      if (w_pps_edge) begin
        pps_timestamp <= timestamp;
        pps_count     <= pps_count + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (load_req) begin
            if (load_mode) begin
              r_hold    <= load_value;
              r_state   <= S_ARMED;
              load_busy <= 1'b1;
            end else begin
              timestamp <= load_value;
              load_done <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          // PPS edge beats a same-cycle cancel; load_req is ignored here.
          if (w_pps_edge) begin
            timestamp <= r_hold;
            load_done <= 1'b1;
            load_busy <= 1'b0;
            r_state   <= S_IDLE;
          end else if (load_cancel) begin
            load_busy <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          load_busy <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`else

  logic w_unused_pps;
  assign w_unused_pps = pps_in ^ load_mode ^ load_cancel;

  // Every request loads immediately; a same-cycle strobe is dropped.
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      timestamp <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_req) begin
        timestamp <= load_value;
        load_done <= 1'b1;
      end else if (w_count) begin
        timestamp <= w_ts_inc;
      end
    end
  end

  assign load_busy     = 1'b0;
  assign pps_timestamp = '0;
  assign pps_count     = '0;

`endif

endmodule

// File: tb/tb_dac_timestamp_counter.sv
// Directed bench for dac_timestamp_counter. Two instances share all inputs:
// u_dut2 with SAMPLES_PER_CHANNEL=2 and u_dut1 with SAMPLES_PER_CHANNEL=1.
module tb_dac_timestamp_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        counter_en;
  logic        sample_strobe;
  logic [63:0] load_value;
  logic        load_mode;
  logic        load_req;
  logic        load_cancel;
  logic        pps_in;

  logic        busy1, done1, busy2, done2;
  logic [63:0] pts1, ts1, pts2, ts2;
  logic [31:0] pcnt1, pcnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_timestamp_counter #(.SAMPLES_PER_CHANNEL(2), .PPS_SYNC_STAGES(2)) u_dut2 (
    .dac_clk(clk), .reset(reset), .counter_en(counter_en), .sample_strobe(sample_strobe),
    .load_value(load_value), .load_mode(load_mode), .load_req(load_req),
    .load_cancel(load_cancel), .load_busy(busy2), .load_done(done2), .pps_in(pps_in),
    .pps_timestamp(pts2), .pps_count(pcnt2), .timestamp(ts2));

  dac_timestamp_counter #(.SAMPLES_PER_CHANNEL(1), .PPS_SYNC_STAGES(2)) u_dut1 (
    .dac_clk(clk), .reset(reset), .counter_en(counter_en), .sample_strobe(sample_strobe),
    .load_value(load_value), .load_mode(load_mode), .load_req(load_req),
    .load_cancel(load_cancel), .load_busy(busy1), .load_done(done1), .pps_in(pps_in),
    .pps_timestamp(pts1), .pps_count(pcnt1), .timestamp(ts1));

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    counter_en = 1'b0; sample_strobe = 1'b0; load_value = '0; load_mode = 1'b0;
    load_req = 1'b0; load_cancel = 1'b0; pps_in = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_now(input logic [63:0] v);
    load_value = v; load_mode = 1'b0; load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic arm(input logic [63:0] v);
    load_value = v; load_mode = 1'b1; load_req = 1'b1;
    tick();
    load_req = 1'b0; load_mode = 1'b0;
  endtask

  task automatic strobes(input int n);
    sample_strobe = 1'b1;
    tick(n);
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ts2 !== 64'd0) begin n_err++; $display("FAIL reset_ts: got %0d expected 0", ts2); end
    n_vec++; if (pts1 !== 64'd0) begin n_err++; $display("FAIL reset_pps_ts: got %0d expected 0", pts1); end
    n_vec++; if (pcnt1 !== 32'd0) begin n_err++; $display("FAIL reset_pps_count: got %0d expected 0", pcnt1); end
    n_vec++; if ({busy1, done1} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {busy1, done1}); end
  endtask

  task automatic test_counting();
    do_reset();
    counter_en = 1'b1;
    strobes(10);
    n_vec++; if (ts2 !== 64'd20) begin n_err++; $display("FAIL count_spc2: got %0d expected 20", ts2); end
    n_vec++; if (ts1 !== 64'd10) begin n_err++; $display("FAIL count_spc1: got %0d expected 10", ts1); end
    counter_en = 1'b0;
    strobes(5);
    n_vec++; if (ts2 !== 64'd20) begin n_err++; $display("FAIL count_disabled: got %0d expected 20", ts2); end
    load_now(64'd77);
    n_vec++; if (ts2 !== 64'd77) begin n_err++; $display("FAIL load_while_disabled: got %0d expected 77", ts2); end
  endtask

  task automatic test_wrap();
    do_reset();
    counter_en = 1'b1;
    load_now(64'hFFFF_FFFF_FFFF_FFFF);
    n_vec++; if (ts1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL wrap_load: got %0h expected ffffffffffffffff", ts1); end
    n_vec++; if (done1 !== 1'b1) begin n_err++; $display("FAIL wrap_load_done: got %b expected 1", done1); end
    strobes(1);
    n_vec++; if (ts1 !== 64'd0) begin n_err++; $display("FAIL wrap_ts: got %0h expected 0", ts1); end
    n_vec++; if ({busy1, done1, pcnt1, pts1} !== 98'd0) begin n_err++; $display("FAIL wrap_side: got busy=%b done=%b cnt=%0d pts=%0d expected all 0", busy1, done1, pcnt1, pts1); end
  endtask

  task automatic test_collision();
    do_reset();
    counter_en = 1'b1;
    load_now(64'd100);
    load_value = 64'd5000; load_req = 1'b1; sample_strobe = 1'b1;
    tick();
    load_req = 1'b0;
    n_vec++; if (ts1 !== 64'd5000) begin n_err++; $display("FAIL collide_ts: got %0d expected 5000", ts1); end
    n_vec++; if (done1 !== 1'b1) begin n_err++; $display("FAIL collide_done: got %b expected 1", done1); end
    tick();
    sample_strobe = 1'b0;
    n_vec++; if (ts1 !== 64'd5001) begin n_err++; $display("FAIL after_load_spc1: got %0d expected 5001", ts1); end
    n_vec++; if (ts2 !== 64'd5002) begin n_err++; $display("FAIL after_load_spc2: got %0d expected 5002", ts2); end
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b expected 0", done1); end
  endtask

`ifdef DAC_TIMESTAMP_PPS_EN
  task automatic test_pps_load();
    do_reset();
    counter_en = 1'b1;
    load_now(64'd40);
    arm(64'd1_000_000);
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b expected 1", busy1); end
    strobes(7);
    n_vec++; if (ts1 !== 64'd47) begin n_err++; $display("FAIL armed_count: got %0d expected 47", ts1); end
    pps_in = 1'b1;
    tick(2);
    n_vec++; if (ts1 !== 64'd47 || pcnt1 !== 32'd0) begin n_err++; $display("FAIL pps_early: got ts=%0d cnt=%0d expected 47/0", ts1, pcnt1); end
    tick();
    n_vec++; if (ts1 !== 64'd1_000_000) begin n_err++; $display("FAIL pps_load_ts: got %0d expected 1000000", ts1); end
    n_vec++; if (pts1 !== 64'd47) begin n_err++; $display("FAIL pps_capture: got %0d expected 47", pts1); end
    n_vec++; if ({done1, busy1} !== 2'b10) begin n_err++; $display("FAIL pps_load_flags: got %b expected 10", {done1, busy1}); end
    n_vec++; if (pcnt1 !== 32'd1) begin n_err++; $display("FAIL pps_count1: got %0d expected 1", pcnt1); end
    tick(5);
    n_vec++; if (pcnt1 !== 32'd1 || done1 !== 1'b0) begin n_err++; $display("FAIL pps_level_once: got cnt=%0d done=%b expected 1/0", pcnt1, done1); end
    pps_in = 1'b0;
    tick(4);
  endtask

  task automatic test_cancel();
    load_now(64'd10);
    arm(64'd999);
    load_cancel = 1'b1;
    tick();
    load_cancel = 1'b0;
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b expected 0", busy1); end
    pps_in = 1'b1;
    tick(3);
    n_vec++; if (ts1 !== 64'd10 || done1 !== 1'b0) begin n_err++; $display("FAIL cancel_no_load: got ts=%0d done=%b expected 10/0", ts1, done1); end
    n_vec++; if (pcnt1 !== 32'd2) begin n_err++; $display("FAIL cancel_pps_count: got %0d expected 2", pcnt1); end
    pps_in = 1'b0;
    tick(4);
  endtask

  task automatic test_cancel_collide();
    arm(64'd555);
    arm(64'd777);
    pps_in = 1'b1;
    tick(2);
    load_cancel = 1'b1;
    tick();
    load_cancel = 1'b0;
    n_vec++; if (ts1 !== 64'd555) begin n_err++; $display("FAIL cancel_vs_edge: got %0d expected 555", ts1); end
    n_vec++; if ({done1, busy1} !== 2'b10) begin n_err++; $display("FAIL cancel_vs_edge_flags: got %b expected 10", {done1, busy1}); end
    n_vec++; if (pts1 !== 64'd10 || pcnt1 !== 32'd3) begin n_err++; $display("FAIL cancel_vs_edge_capture: got pts=%0d cnt=%0d expected 10/3", pts1, pcnt1); end
    pps_in = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_armed();
    arm(64'd4242);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_armed_busy: got %b expected 0", busy1); end
    pps_in = 1'b1;
    tick(3);
    n_vec++; if (ts1 !== 64'd0 || done1 !== 1'b0) begin n_err++; $display("FAIL reset_armed_no_load: got ts=%0d done=%b expected 0/0", ts1, done1); end
    n_vec++; if (pcnt1 !== 32'd1) begin n_err++; $display("FAIL reset_armed_pps_count: got %0d expected 1", pcnt1); end
    counter_en = 1'b1;
    strobes(3);
    n_vec++; if (ts1 !== 64'd3) begin n_err++; $display("FAIL reset_armed_count: got %0d expected 3", ts1); end
    pps_in = 1'b0;
  endtask
`else
  task automatic test_no_pps();
    do_reset();
    arm(64'd321);
    n_vec++; if (ts1 !== 64'd321) begin n_err++; $display("FAIL mode1_immediate: got %0d expected 321", ts1); end
    n_vec++; if ({done1, busy1} !== 2'b10) begin n_err++; $display("FAIL mode1_flags: got %b expected 10", {done1, busy1}); end
    pps_in = 1'b1;
    tick(5);
    pps_in = 1'b0;
    tick(5);
    n_vec++; if (pcnt1 !== 32'd0 || pts1 !== 64'd0) begin n_err++; $display("FAIL pps_tied_off: got cnt=%0d pts=%0d expected 0/0", pcnt1, pts1); end
    n_vec++; if (ts1 !== 64'd321) begin n_err++; $display("FAIL pps_no_effect: got %0d expected 321", ts1); end
  endtask
`endif

  initial begin
    test_reset();
    test_counting();
    test_wrap();
    test_collision();
`ifdef DAC_TIMESTAMP_PPS_EN
    test_pps_load();
    test_cancel();
    test_cancel_collide();
    test_reset_armed();
`else
    test_no_pps();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
